rr_stream_arb: RTL and testbench
================================

// Module: rr_stream_arb
// PURPOSE
//  Two-input round-robin stream arbiter with packet locking; sits directly upstream of the 2:1 mux.
//  Picks which of two valid/ready sources owns the shared path, drives the mux select, and registers the winning beat.
//  Grant is held from first beat to the beat flagged last, so packets never interleave.
// PARAMETERS
//  WIDTH  8  data bits per beat on every data port
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  in0_valid  in   1      source 0 beat available
//  in0_data   in   WIDTH  source 0 beat
//  in0_last   in   1      source 0 beat ends its packet
//  in0_ready  out  1      source 0 beat accepted this cycle when in0_valid&in0_ready
//  in1_valid  in   1      source 1 beat available
//  in1_data   in   WIDTH  source 1 beat
//  in1_last   in   1      source 1 beat ends its packet
//  in1_ready  out  1      source 1 beat accepted this cycle when in1_valid&in1_ready
//  out_valid  out  1      registered beat available downstream
//  out_data   out  WIDTH  registered beat
//  out_last   out  1      registered last flag
//  out_ready  in   1      downstream accepts when out_valid&out_ready
//  sel        out  1      registered grant owner (0=in0, 1=in1); drives mux select
//  busy       out  1      1 while a packet is locked (state != IDLE)
// BEHAVIOUR
//  - States: IDLE, LOCK0, LOCK1. sel=1 only in LOCK1; busy=1 in LOCK0/LOCK1.
//  - Reset (rst=1 at edge): state=IDLE, prio=0 (in0 favoured), out_valid=0, out_data=0, out_last=0, sel=0, busy=0.
//    Reset mid-packet drops the lock and any held output beat; no beat survives reset.
//  - IDLE arbitration (registered): only in0_valid -> LOCK0; only in1_valid -> LOCK1;
//    both -> LOCK<prio>; neither -> stay IDLE. No beat is accepted in IDLE.
//  - inX_ready = (state==LOCKX) & (~out_valid | out_ready); non-granted ready is always 0.
//  - Accepted beat loads out_data/out_last next edge, out_valid=1. If out_valid&out_ready and no new accept, out_valid->0.
//  - Output register stable (data, last, valid) while out_valid & ~out_ready.
//  - Accepting a beat with last=1 in LOCKX: next state IDLE, prio <= ~X. Otherwise stay LOCKX.
//  - In LOCKX, inX_valid low just stalls; lock is never released without a last beat (or reset).
//  - Latency: inX_valid rises in IDLE at cycle N -> ready at N+1 (if output free) -> out_valid at N+2.
//  - Throughput: 1 beat/cycle inside a packet; one IDLE bubble between packets.
//  - Simultaneous out_ready and accept: old beat leaves, new beat loads same edge, out_valid stays 1.
//  - Input data/last ignored unless the beat is accepted; no width conversion, data passed bit-exact.
// TESTING
//  1. Reset: assert rst 2 cycles with both valids high -> all outputs 0, state IDLE, no ready asserted.
//  2. Single source: in0 sends 3-beat packet 0x11,0x22,0x33(last), out_ready=1 -> out_data 0x11,0x22,0x33
//     on consecutive cycles, first at cycle N+2, sel=0, busy drops after last.
//  3. Contention: both send 1-beat packets continuously -> grants alternate in0,in1,in0,...; sel toggles; no beat lost.
//  4. Lock: in1 mid-packet (2 of 4 beats) while in0_valid high -> in0_ready stays 0 until in1 last accepted.
//  5. Backpressure: out_ready=0 for 4 cycles with out_data=0xA5 -> out_data/out_valid held, granted ready=0; release -> 0xA5 taken once.
//  6. Reset mid-packet: rst during LOCK1 with out_valid=1 -> next cycle out_valid=0, IDLE, prio=0 (in0 wins tie).

Source files
------------

// File: rtl/rr_stream_arb.sv
// Two-input round-robin stream arbiter with packet locking and a registered output beat.
// The grant is held from a packet's first beat until its last beat is accepted.
module rr_stream_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             prio_r;
  logic             prio_nx_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_last_r;
  logic             sel_r;
  logic             busy_r;
  logic             out_free_s;
  logic             acc0_s;
  logic             acc1_s;
  logic             acc_s;
  logic [WIDTH-1:0] acc_data_s;
  logic             acc_last_s;

  // Handshake decode, accepted-beat mux and next-state arbitration.
  always_comb begin
    out_free_s = ~out_valid_r | out_ready;
    acc0_s     = (state_r == LOCK0) & out_free_s & in0_valid;
    acc1_s     = (state_r == LOCK1) & out_free_s & in1_valid;
    acc_s      = acc0_s | acc1_s;
    if (acc1_s) begin
      acc_data_s = in1_data;
      acc_last_s = in1_last;
    end else begin
      acc_data_s = in0_data;
      acc_last_s = in0_last;
    end
    state_nx_s = state_r;
    prio_nx_s  = prio_r;
    case (state_r)
      IDLE: begin
        // On a tie the favoured source wins; otherwise whoever is valid.
        if (in1_valid & (~in0_valid | prio_r)) begin
          state_nx_s = LOCK1;
        end else if (in0_valid) begin
          state_nx_s = LOCK0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOCK0: begin
        if (acc0_s & in0_last) begin
          state_nx_s = IDLE;
          prio_nx_s  = 1'b1;
        end else begin
          state_nx_s = LOCK0;
        end
      end
      LOCK1: begin
        if (acc1_s & in1_last) begin
          state_nx_s = IDLE;
          prio_nx_s  = 1'b0;
        end else begin
          state_nx_s = LOCK1;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, priority, registered grant flags and the output beat register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      prio_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_last_r  <= 1'b0;
      sel_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      prio_r  <= prio_nx_s;
      sel_r   <= (state_nx_s == LOCK1);
      busy_r  <= (state_nx_s != IDLE);
      if (acc_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= acc_data_s;
        out_last_r  <= acc_last_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in0_ready = (state_r == LOCK0) & out_free_s;
  assign in1_ready = (state_r == LOCK1) & out_free_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign sel       = sel_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rr_stream_arb.sv
// Directed and randomized checks of rr_stream_arb against a packet-level scoreboard.
// Inputs change and outputs are sampled 1-2 time units after each rising edge.
module tb_rr_stream_arb;

  localparam int NB = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in0_valid = 1'b0, in1_valid = 1'b0;
  logic [7:0] in0_data = 8'h00, in1_data = 8'h00;
  logic       in0_last = 1'b0, in1_last = 1'b0;
  logic       in0_ready, in1_ready;
  logic       out_valid, out_last, out_ready = 1'b0;
  logic [7:0] out_data;
  logic       sel, busy;

  int checks = 0;
  int errors = 0;

  rr_stream_arb #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  logic [8:0] beats [2][NB+1];
  logic [7:0] expq [$];
  int         idx [2];
  int         oidx [2];
  int         c0, c1, k, s;
  logic       a0, a1, turn, in_pkt, pkt_src;

  initial begin
    // 1. reset with both valids high
    rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    tick; tick;
    chk("rst_out_valid", 9'(out_valid), 9'd0);
    chk("rst_out_data", 9'(out_data), 9'd0);
    chk("rst_out_last", 9'(out_last), 9'd0);
    chk("rst_sel", 9'(sel), 9'd0);
    chk("rst_busy", 9'(busy), 9'd0);
    chk("rst_ready", 9'({in0_ready, in1_ready}), 9'd0);

    // 2. single source, 3-beat packet
    rst = 1'b0; in1_valid = 1'b0; in0_valid = 1'b1; in0_data = 8'h11; in0_last = 1'b0; out_ready = 1'b1;
    #1;
    chk("idle_no_ready", 9'(in0_ready), 9'd0);
    tick;
    chk("grant_busy", 9'(busy), 9'd1);
    chk("grant_sel", 9'(sel), 9'd0);
    chk("grant_no_out", 9'(out_valid), 9'd0);
    chk("grant_ready", 9'(in0_ready), 9'd1);
    tick;
    chk("beat0", {out_valid, out_data}, {1'b1, 8'h11});
    in0_data = 8'h22;
    tick;
    chk("beat1", {out_valid, out_data}, {1'b1, 8'h22});
    in0_data = 8'h33; in0_last = 1'b1;
    tick;
    chk("beat2", {out_last, out_data}, {1'b1, 8'h33});
    chk("beat2_busy", 9'(busy), 9'd0);
    in0_valid = 1'b0;
    tick;
    chk("drain_valid", 9'(out_valid), 9'd0);

    // 3. contention with 1-beat packets; in0 just ended a packet so in1 is favoured
    turn = 1'b1; c0 = 0; c1 = 0;
    in0_valid = 1'b1; in1_valid = 1'b1; in0_last = 1'b1; in1_last = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (cyc == 12) begin
        in0_valid = 1'b0; in1_valid = 1'b0;
      end
      in0_data = 8'h40 + 8'(c0); in1_data = 8'hC0 + 8'(c1);
      #1;
      a0 = in0_valid & in0_ready; a1 = in1_valid & in1_ready;
      if (a0 | a1) begin
        chk("arb_turn", 9'(a1), 9'(turn));
        chk("arb_sel", 9'(sel), 9'(a1));
        expq.push_back(a1 ? in1_data : in0_data);
        turn = ~turn;
      end
      if (out_valid) begin
        chk("arb_q_nonempty", 9'(expq.size() != 0), 9'd1);
        if (expq.size() != 0) chk("arb_beat", 9'(out_data), 9'(expq.pop_front()));
      end
      tick;
      if (a0) c0++;
      if (a1) c1++;
    end
    chk("arb_count", 9'(c0 + c1), 9'd6);
    chk("arb_lost", 9'(expq.size()), 9'd0);

    // 4. in0 locked out while in1 finishes a 4-beat packet (with one stall)
    in0_valid = 1'b0; in0_last = 1'b1; in0_data = 8'h5C; in1_valid = 1'b1; k = 0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      in0_valid = (k >= 2);
      in1_valid = (cyc != 4);
      in1_data = 8'hB0 + 8'(k); in1_last = (k == 3);
      #1;
      chk("lock_in0_ready", 9'(in0_ready), 9'd0);
      a1 = in1_valid & in1_ready;
      tick;
      if (a1) k++;
    end
    chk("lock_beats", 9'(k), 9'd4);
    in1_valid = 1'b0;
    chk("lock_released", 9'(busy), 9'd0);
    tick;
    chk("lock_next_sel", {busy, sel}, 9'b10);
    chk("lock_next_ready", 9'(in0_ready), 9'd1);
    tick;
    in0_valid = 1'b0;

    // 5. backpressure holds 0xA5 for 4 cycles, then it leaves once
    in0_valid = 1'b1; in0_data = 8'hA5; in0_last = 1'b0; out_ready = 1'b1;
    tick; tick;
    chk("bp_load", {out_valid, out_data}, {1'b1, 8'hA5});
    out_ready = 1'b0; in0_data = 8'h5A; in0_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", 9'(in0_ready), 9'd0);
      tick;
      chk("bp_hold", {out_valid, out_data}, {1'b1, 8'hA5});
      chk("bp_hold_last", 9'(out_last), 9'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 9'(in0_ready), 9'd1);
    tick;
    chk("bp_swap", {out_valid, out_data}, {1'b1, 8'h5A});
    in0_valid = 1'b0;
    tick;
    chk("bp_once", 9'(out_valid), 9'd0);

    // 6. reset mid-packet in LOCK1 with a held beat; in1 is favoured beforehand
    in1_valid = 1'b1; in1_data = 8'hE1; in1_last = 1'b0;
    tick;
    chk("rmid_sel", 9'(sel), 9'd1);
    tick;
    chk("rmid_loaded", 9'(out_valid), 9'd1);
    out_ready = 1'b0; rst = 1'b1;
    tick;
    chk("rmid_out_valid", 9'(out_valid), 9'd0);
    chk("rmid_state", {busy, sel}, 9'd0);
    chk("rmid_data", 9'(out_data), 9'd0);
    rst = 1'b0; in0_valid = 1'b1; in0_data = 8'h0F; in0_last = 1'b1; out_ready = 1'b1;
    #1;
    chk("rmid_ready", 9'({in0_ready, in1_ready}), 9'd0);
    tick;
    chk("rmid_tie_in0", {busy, sel}, 9'b10);
    tick;
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick;

    // 7. random traffic: per-source order, no interleaving, nothing lost
    rst = 1'b1; tick; rst = 1'b0;
    for (int src = 0; src < 2; src++) begin
      for (int b = 0; b <= NB; b++)
        beats[src][b] = {($urandom_range(0, 2) == 0) || (b == NB - 1), src[0], 7'(b)};
      idx[src] = 0; oidx[src] = 0;
    end
    in_pkt = 1'b0; pkt_src = 1'b0;
    for (int cyc = 0; cyc < 4000 && !(oidx[0] == NB && oidx[1] == NB); cyc++) begin
      in0_valid = (idx[0] < NB) && ($urandom_range(0, 3) != 0);
      in1_valid = (idx[1] < NB) && ($urandom_range(0, 3) != 0);
      {in0_last, in0_data} = beats[0][idx[0]];
      {in1_last, in1_data} = beats[1][idx[1]];
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      a0 = in0_valid & in0_ready; a1 = in1_valid & in1_ready;
      chk("rnd_excl", 9'(in0_ready & in1_ready), 9'd0);
      if (a0 | a1) chk("rnd_sel", 9'(sel), 9'(a1));
      if (out_valid & out_ready) begin
        s = int'(out_data[7]);
        if (oidx[s] < NB) chk("rnd_beat", {out_last, out_data}, beats[s][oidx[s]]);
        else chk("rnd_extra", 9'd1, 9'd0);
        if (in_pkt) chk("rnd_interleave", 9'(s), 9'(pkt_src));
        in_pkt = ~out_last; pkt_src = s[0];
        oidx[s]++;
      end
      tick;
      if (a0) idx[0]++;
      if (a1) idx[1]++;
    end
    chk("rnd_done0", 9'(oidx[0]), 9'(NB));
    chk("rnd_done1", 9'(oidx[1]), 9'(NB));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
